exc_ctrl: RTL and testbench

Exception/interrupt sequencer between the pipeline's commit stage and the CP0 register block. It prioritises all exception sources and pending interrupts for the instruction at commit. It waits for any outstanding data-bus transaction to drain. It then issues a single-cycle exception/ERET strobe to CP0, flushes the pipeline, and holds a PC redirect until the fetch unit accepts it.

---
 rtl/exc_ctrl_pkg.sv | 23 ++
 rtl/exc_prio.sv | 54 +++++
 rtl/exc_ctrl.sv | 132 +++++++++++++
 tb/tb_exc_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception sequencer: MIPS ExcCodes, FSM state
// encodings and the two exception vector addresses.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] VEC_BEV1 = 32'hBFC0_0380;
  localparam logic [31:0] VEC_BEV0 = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } exc_state_e;

endpackage

// File: rtl/exc_prio.sv
// Combinational priority encoder: picks the winning exception source for the
// commit instruction, or flags an ERET when no exception is present.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic        int_req,
  input  logic        c_if_adel,
  input  logic        c_ri,
  input  logic        c_ov,
  input  logic        c_sys,
  input  logic        c_bp,
  input  logic        c_d_adel,
  input  logic        c_d_ades,
  input  logic        c_eret,
  input  logic [31:0] c_pc,
  input  logic [31:0] c_d_vaddr,
  output logic        hit,
  output logic [4:0]  excode,
  output logic [31:0] badvaddr,
  output logic        is_eret
);

  always_comb begin
    excode   = '0;
    badvaddr = '0;
    is_eret  = 1'b0;
    hit      = int_req | c_if_adel | c_ri | c_ov | c_sys | c_bp |
               c_d_adel | c_d_ades | c_eret;
    if (int_req) begin
      excode = EXC_INT;
    end else if (c_if_adel) begin
      excode   = EXC_ADEL;
      badvaddr = c_pc;
    end else if (c_ri) begin
      excode = EXC_RI;
    end else if (c_ov) begin
      excode = EXC_OV;
    end else if (c_sys) begin
      excode = EXC_SYS;
    end else if (c_bp) begin
      excode = EXC_BP;
    end else if (c_d_adel) begin
      excode   = EXC_ADEL;
      badvaddr = c_d_vaddr;
    end else if (c_d_ades) begin
      excode   = EXC_ADES;
      badvaddr = c_d_vaddr;
    end else if (c_eret) begin
      // ERET only redirects when nothing above it fired; excode stays 0.
      is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: captures the commit-stage event, drains the
// data bus, strobes CP0 for one cycle, flushes and holds a fetch redirect.
// Redirect handshake: redirect_valid is held with a stable redirect_pc until a
// cycle where redirect_valid & redirect_ready are both high at the clock edge.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        c_valid,
  input  logic [31:0] c_pc,
  input  logic        c_bd,
  input  logic        c_if_adel,
  input  logic        c_ri,
  input  logic        c_ov,
  input  logic        c_sys,
  input  logic        c_bp,
  input  logic        c_d_adel,
  input  logic        c_d_ades,
  input  logic        c_eret,
  input  logic [31:0] c_d_vaddr,
  input  logic        int_req,
  input  logic        status_bev,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  output logic        commit_block,
  output logic        ex_valid,
  output logic        ex_eret,
  output logic [4:0]  ex_excode,
  output logic        ex_bd,
  output logic [31:0] ex_epc,
  output logic [31:0] ex_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output exc_state_e  state_dbg
);

  exc_state_e  state_q, state_d;
  logic [4:0]  excode_q, excode_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        eret_q, eret_d;
  logic [31:0] target_q, target_d;

  logic        prio_hit, prio_eret, evt;
  logic [4:0]  prio_excode;
  logic [31:0] prio_badvaddr;

  exc_prio u_prio (
    .int_req   (int_req),
    .c_if_adel (c_if_adel),
    .c_ri      (c_ri),
    .c_ov      (c_ov),
    .c_sys     (c_sys),
    .c_bp      (c_bp),
    .c_d_adel  (c_d_adel),
    .c_d_ades  (c_d_ades),
    .c_eret    (c_eret),
    .c_pc      (c_pc),
    .c_d_vaddr (c_d_vaddr),
    .hit       (prio_hit),
    .excode    (prio_excode),
    .badvaddr  (prio_badvaddr),
    .is_eret   (prio_eret)
  );

  assign evt = (state_q == ST_IDLE) & c_valid & prio_hit;

  always_comb begin
    state_d    = state_q;
    excode_d   = excode_q;
    bd_d       = bd_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    eret_d     = eret_q;
    target_d   = target_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d    = mem_busy ? ST_DRAIN : ST_COMMIT;
          excode_d   = prio_excode;
          bd_d       = c_bd;
          epc_d      = c_bd ? (c_pc - 32'd4) : c_pc;
          badvaddr_d = prio_badvaddr;
          eret_d     = prio_eret;
          target_d   = prio_eret ? cp0_epc : (status_bev ? VEC_BEV1 : VEC_BEV0);
        end
      end
      ST_DRAIN:    if (!mem_busy) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      excode_q   <= '0;
      bd_q       <= 1'b0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      eret_q     <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      excode_q   <= excode_d;
      bd_q       <= bd_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      eret_q     <= eret_d;
      target_q   <= target_d;
    end
  end

  // CP0 payload is only presented alongside its strobe so stale captures never leak.
  assign commit_block   = evt | (state_q != ST_IDLE);
  assign ex_valid       = (state_q == ST_COMMIT);
  assign ex_eret        = ex_valid & eret_q;
  assign ex_excode      = ex_valid ? excode_q : 5'd0;
  assign ex_bd          = ex_valid & bd_q;
  assign ex_epc         = ex_valid ? epc_q : 32'd0;
  assign ex_badvaddr    = ex_valid ? badvaddr_q : 32'd0;
  assign flush          = (state_q == ST_COMMIT) | (state_q == ST_REDIRECT);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : 32'd0;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenario tasks plus a scoreboard
// that pairs every CP0 strobe and fetch redirect with its expected payload.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam int EXP_W = 103;  // {eret, excode, bd, epc, badvaddr, target}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        c_valid = 1'b0;
  logic [31:0] c_pc = '0;
  logic        c_bd = 1'b0;
  logic        c_if_adel = 1'b0, c_ri = 1'b0, c_ov = 1'b0, c_sys = 1'b0;
  logic        c_bp = 1'b0, c_d_adel = 1'b0, c_d_ades = 1'b0, c_eret = 1'b0;
  logic [31:0] c_d_vaddr = '0;
  logic        int_req = 1'b0;
  logic        status_bev = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic        mem_busy = 1'b0;
  logic        redirect_ready = 1'b1;
  logic        commit_block, ex_valid, ex_eret, ex_bd, flush, redirect_valid;
  logic [4:0]  ex_excode;
  logic [31:0] ex_epc, ex_badvaddr, redirect_pc;
  exc_state_e  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      tgt_q[$];
  logic [EXP_W-1:0] mon_e;

  exc_ctrl dut (
    .clk(clk), .resetn(resetn), .c_valid(c_valid), .c_pc(c_pc), .c_bd(c_bd),
    .c_if_adel(c_if_adel), .c_ri(c_ri), .c_ov(c_ov), .c_sys(c_sys), .c_bp(c_bp),
    .c_d_adel(c_d_adel), .c_d_ades(c_d_ades), .c_eret(c_eret),
    .c_d_vaddr(c_d_vaddr), .int_req(int_req), .status_bev(status_bev),
    .cp0_epc(cp0_epc), .mem_busy(mem_busy), .commit_block(commit_block),
    .ex_valid(ex_valid), .ex_eret(ex_eret), .ex_excode(ex_excode), .ex_bd(ex_bd),
    .ex_epc(ex_epc), .ex_badvaddr(ex_badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // f bits: [8]int [7]if_adel [6]ri [5]ov [4]sys [3]bp [2]d_adel [1]d_ades [0]eret
  function automatic logic [EXP_W-1:0] exp_of(input logic [8:0] f, input logic [31:0] pc,
                                               input logic bd, input logic [31:0] vaddr,
                                               input logic bev, input logic [31:0] epc_in);
    logic [4:0]  code;
    logic [31:0] bad, epc, tgt;
    logic        er;
    code = 5'h00; bad = 32'd0; er = 1'b0;
    if (f[8])      code = 5'h00;
    else if (f[7]) begin code = 5'h04; bad = pc; end
    else if (f[6]) code = 5'h0a;
    else if (f[5]) code = 5'h0c;
    else if (f[4]) code = 5'h08;
    else if (f[3]) code = 5'h09;
    else if (f[2]) begin code = 5'h04; bad = vaddr; end
    else if (f[1]) begin code = 5'h05; bad = vaddr; end
    else           er = 1'b1;
    epc = bd ? pc - 32'd4 : pc;
    tgt = er ? epc_in : (bev ? 32'hBFC00380 : 32'h80000180);
    return {er, code, bd, epc, bad, tgt};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (resetn) begin
      if (ex_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_strobe excode=%h epc=%h with no expected event", ex_excode, ex_epc);
        end else begin
          mon_e = exp_q.pop_front();
          if ({ex_eret, ex_excode, ex_bd, ex_epc, ex_badvaddr} !== mon_e[EXP_W-1:32]) begin
            errors++;
            $display("FAIL sb_cp0 got eret=%b code=%h bd=%b epc=%h bad=%h exp eret=%b code=%h bd=%b epc=%h bad=%h",
                     ex_eret, ex_excode, ex_bd, ex_epc, ex_badvaddr,
                     mon_e[102], mon_e[101:97], mon_e[96], mon_e[95:64], mon_e[63:32]);
          end
          tgt_q.push_back(mon_e[31:0]);
        end
      end
      if (redirect_valid) begin
        checks++;
        if (tgt_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_redirect pc=%h", redirect_pc);
        end else begin
          if (redirect_pc !== tgt_q[0] || flush !== 1'b1) begin
            errors++;
            $display("FAIL sb_redirect got pc=%h flush=%b exp pc=%h flush=1", redirect_pc, flush, tgt_q[0]);
          end
          if (redirect_ready) void'(tgt_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_flags(input logic [8:0] f);
    int_req   = f[8]; c_if_adel = f[7]; c_ri   = f[6]; c_ov     = f[5];
    c_sys     = f[4]; c_bp      = f[3]; c_d_adel = f[2]; c_d_ades = f[1];
    c_eret    = f[0];
  endtask

  // Presents one event for one cycle (DUT must be idle) and queues its expectation.
  task automatic drive_event(input logic [8:0] f, input logic [31:0] pc, input logic bd,
                             input logic [31:0] vaddr, input logic bev, input logic [31:0] epc_in);
    @(posedge clk); #1;
    c_valid = 1'b1; c_pc = pc; c_bd = bd; c_d_vaddr = vaddr;
    status_bev = bev; cp0_epc = epc_in;
    set_flags(f);
    exp_q.push_back(exp_of(f, pc, bd, vaddr, bev, epc_in));
    @(negedge clk);
    checks++;
    if (commit_block !== 1'b1 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL event_commit_block got blk=%b st=%0d exp blk=1 st=0", commit_block, state_dbg);
    end
    @(posedge clk); #1;
    c_valid = 1'b0;
    set_flags(9'd0);
    // Capture must have happened: scramble the sources to prove they are not re-read.
    c_pc = $urandom; c_d_vaddr = $urandom; cp0_epc = $urandom; status_bev = ~bev; c_bd = ~bd;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (state_dbg == ST_IDLE) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle timeout got st=%0d exp st=0 within %0d cycles", state_dbg, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({commit_block, ex_valid, ex_eret, ex_excode, ex_bd, ex_epc, ex_badvaddr,
         flush, redirect_valid, redirect_pc} !== '0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_outputs got blk=%b exv=%b fl=%b rv=%b st=%0d exp all 0",
               commit_block, ex_valid, flush, redirect_valid, state_dbg);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_ov_latency;
    drive_event(9'b0_0010_0000, 32'hBFC00100, 1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ov_t1 got exv=%b fl=%b rv=%b exp 1 1 0", ex_valid, flush, redirect_valid);
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380) begin
      errors++;
      $display("FAIL ov_t2 got exv=%b rv=%b pc=%h exp 0 1 bfc00380", ex_valid, redirect_valid, redirect_pc);
    end
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE || flush !== 1'b0 || redirect_valid !== 1'b0 || commit_block !== 1'b0) begin
      errors++;
      $display("FAIL ov_t3 got st=%0d fl=%b rv=%b blk=%b exp idle 0 0 0", state_dbg, flush, redirect_valid, commit_block);
    end
  endtask

  task automatic test_drain(input int n, input logic [8:0] f, input logic [31:0] pc,
                            input logic bd, input logic [31:0] vaddr);
    int  cnt = 0;
    bit  seen = 1'b0;
    mem_busy = 1'b1;
    drive_event(f, pc, bd, vaddr, 1'b0, 32'h0);
    for (int i = 0; i < n + 10 && !seen; i++) begin
      @(negedge clk);
      if (state_dbg == ST_DRAIN) begin
        cnt++;
        if (ex_valid || redirect_valid) begin
          errors++;
          $display("FAIL drain_leak got exv=%b rv=%b exp 0 0", ex_valid, redirect_valid);
        end
        if (cnt == n) mem_busy = 1'b0;
      end
      if (ex_valid) seen = 1'b1;
    end
    mem_busy = 1'b0;
    checks++;
    if (!seen || cnt != n) begin
      errors++;
      $display("FAIL drain_cycles got drain=%0d strobe=%b exp drain=%0d strobe=1", cnt, seen, n);
    end
    wait_idle(10);
  endtask

  task automatic test_redirect_hold;
    redirect_ready = 1'b0;
    drive_event(9'b0_0000_1000, 32'h80002000, 1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);  // COMMIT cycle, checked by scoreboard
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (redirect_valid !== 1'b1 || flush !== 1'b1 || ex_valid !== 1'b0 || commit_block !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got rv=%b fl=%b exv=%b blk=%b exp 1 1 0 1",
                 i, redirect_valid, flush, ex_valid, commit_block);
      end
      if (i == 1) begin c_valid = 1'b1; c_ov = 1'b1; int_req = 1'b1; end
      if (i == 2) begin c_valid = 1'b0; c_ov = 1'b0; int_req = 1'b0; end
      if (i == 3) redirect_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got st=%0d exv=%b exp idle 0", state_dbg, ex_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_valid;
    @(posedge clk); #1;
    c_valid = 1'b0;
    set_flags(9'h1FF);
    @(negedge clk);
    checks++;
    if (commit_block !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_block got %b exp 0", commit_block);
    end
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_state got st=%0d exv=%b exp idle 0", state_dbg, ex_valid);
    end
    set_flags(9'd0);
  endtask

  task automatic test_reset_mid;
    mem_busy = 1'b1;
    drive_event(9'b0_0100_0000, 32'h80004000, 1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_DRAIN) begin
      errors++;
      $display("FAIL rst_mid_drain got st=%0d exp 1", state_dbg);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({commit_block, ex_valid, ex_eret, ex_excode, flush, redirect_valid, redirect_pc} !== '0 ||
        state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_async got blk=%b exv=%b fl=%b rv=%b st=%0d exp all 0",
               commit_block, ex_valid, flush, redirect_valid, state_dbg);
    end
    mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    tgt_q.delete();
    @(negedge clk); resetn = 1'b1;
    drive_event(9'b0_0000_0001, 32'h80005000, 1'b0, 32'h0, 1'b0, 32'hBFC00444);
    wait_idle(10);
  endtask

  task automatic test_back_to_back;
    logic [8:0]  f;
    logic [31:0] pc, va, ep;
    for (int i = 0; i < 12; i++) begin
      f  = 9'($urandom_range(1, 511));
      pc = $urandom; va = $urandom; ep = $urandom;
      drive_event(f, pc, 1'($urandom_range(0, 1)), va, 1'($urandom_range(0, 1)), ep);
      wait_idle(10);
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    test_reset;
    test_ov_latency;
    test_drain(3, 9'b0_0000_0010, 32'h80001008, 1'b1, 32'h80000003);   // data AdES in delay slot
    test_drain($urandom_range(1, 5), 9'b0_0000_0100, 32'h80001100, 1'b0, 32'h80000021);
    drive_event(9'b1_0000_0001, 32'h80003000, 1'b0, 32'h0, 1'b0, 32'hBFC00444);  // int + ERET
    wait_idle(10);
    drive_event(9'b0_0000_0001, 32'h80003004, 1'b0, 32'h0, 1'b1, 32'hBFC00444);  // ERET alone
    wait_idle(10);
    drive_event(9'b0_0001_0010, 32'h80003008, 1'b0, 32'h80000007, 1'b1, 32'h0);  // Sys + AdES
    wait_idle(10);
    drive_event(9'b0_1000_0100, 32'h00000000, 1'b1, 32'h0000_0011, 1'b0, 32'h0); // fetch AdEL, epc wraps
    wait_idle(10);
    test_redirect_hold;
    test_no_valid;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || tgt_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending strobes=%0d redirects=%0d exp 0 0", exp_q.size(), tgt_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
